// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner of the
// w = d ? ~(a & b) : ~c gate.
package tt_scan_pkg;

  localparam int VEC_W = 4;
  localparam int N_VEC = 16;

  // Golden table, bit index = {a,b,c,d} with a as the MSB.
  localparam logic [N_VEC-1:0] GATE_W_TABLE = 16'h1BBB;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

  function automatic logic [VEC_W-1:0] next_vec(input logic [VEC_W-1:0] v);
    return v + VEC_W'(1);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-window counter: counts enabled cycles and flags the last one.
// Synchronous clear has priority over enable.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/tt_scanner.sv
// Drives all 16 {a,b,c,d} vectors onto the gate, samples w after each settle window
// and builds the observed truth table. Golden compare is built only with TT_SCAN_COMPARE_EN.
module tt_scanner
  import tt_scan_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 4,
  parameter logic [N_VEC-1:0] EXPECTED      = GATE_W_TABLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              w_in,
  output logic [VEC_W-1:0]  abcd,
  output logic              busy,
  output logic              done,
  output logic [N_VEC-1:0]  table_out,
  output logic              mismatch,
  output logic [VEC_W-1:0]  fail_idx
);

  scan_state_t      state;
  logic [VEC_W-1:0] idx;
  logic             timer_clear;
  logic             timer_en;
  logic             settle_tc;
  logic             launch;

  assign launch      = start && (state == IDLE || state == DONE);
  assign timer_clear = launch || (state == SAMPLE);
  assign timer_en    = (state == SETTLE);

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .tc     (settle_tc)
  );

`ifdef TT_SCAN_COMPARE_EN
  logic             mismatch_q;
  logic [VEC_W-1:0] fail_idx_q;

  assign mismatch = mismatch_q;
  assign fail_idx = fail_idx_q;
`else
  wire unused_expected = ^EXPECTED;

  assign mismatch = 1'b0;
  assign fail_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      abcd      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
`ifdef TT_SCAN_COMPARE_EN
      mismatch_q <= 1'b0;
      fail_idx_q <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            abcd      <= '0;
            table_out <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= SETTLE;
`ifdef TT_SCAN_COMPARE_EN
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
`endif
          end
        end
        SETTLE: begin
          if (settle_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_out[idx] <= w_in;
`ifdef TT_SCAN_COMPARE_EN
          // An X/Z sample makes the compare unknown, so it never flags here.
          if ((w_in != EXPECTED[idx]) && !mismatch_q) begin
            mismatch_q <= 1'b1;
            fail_idx_q <= idx;
          end
`endif
          if (idx == VEC_W'(N_VEC - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= next_vec(idx);
            abcd  <= next_vec(idx);
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_scanner.sv
// Self-checking bench for tt_scanner: default and SETTLE_CYCLES=1 instances against a
// table/arrival-time model of the scan, with directed and randomly faulted gate models.
module tb_tt_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  int          gate_mode;
  logic [15:0] fault_mask;

  logic        start_a, start_b, w_a, w_b;
  logic [3:0]  abcd_a, abcd_b, fidx_a, fidx_b;
  logic        busy_a, busy_b, done_a, done_b, mis_a, mis_b;
  logic [15:0] tab_a, tab_b;

  logic [3:0]  obs_abcd, obs_fidx;
  logic        obs_busy, obs_done, obs_mis;
  logic [15:0] obs_tab;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  tt_scanner u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .w_in(w_a),
    .abcd(abcd_a), .busy(busy_a), .done(done_a),
    .table_out(tab_a), .mismatch(mis_a), .fail_idx(fidx_a)
  );

  tt_scanner #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .w_in(w_b),
    .abcd(abcd_b), .busy(busy_b), .done(done_b),
    .table_out(tab_b), .mismatch(mis_b), .fail_idx(fidx_b)
  );

  // Gate under test: the true function, or one of several faulty variants.
  function automatic logic gate_fn(input logic [3:0] v, input int mode, input logic [15:0] fm);
    logic good;
    good = v[0] ? ~(v[3] & v[2]) : ~v[1];
    case (mode)
      1:       return 1'b0;
      2:       return good | (v == 4'd13);
      3:       return good ^ fm[v];
      default: return good;
    endcase
  endfunction

  always_comb begin
    w_a = gate_fn(abcd_a, gate_mode, fault_mask);
    w_b = gate_fn(abcd_b, gate_mode, fault_mask);
  end

  always_comb begin
    obs_abcd = sel ? abcd_b : abcd_a;
    obs_busy = sel ? busy_b : busy_a;
    obs_done = sel ? done_b : done_a;
    obs_tab  = sel ? tab_b  : tab_a;
    obs_mis  = sel ? mis_b  : mis_a;
    obs_fidx = sel ? fidx_b : fidx_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full scan on the selected instance, checked cycle by cycle against arrival times.
  task automatic do_scan(input logic use_b, input int mode, input logic [15:0] fm,
                         input string name);
    int          s;
    int          j;
    logic [15:0] exp_tab;
    logic        exp_mis;
    logic [3:0]  exp_fidx;
    logic [15:0] diff;
    s          = use_b ? 1 : 4;
    sel        = use_b;
    gate_mode  = mode;
    fault_mask = fm;
    for (int k = 0; k < 16; k++) exp_tab[k] = gate_fn(4'(k), mode, fm);
    diff     = exp_tab ^ 16'h1BBB;
    exp_mis  = 1'b0;
    exp_fidx = 4'd0;
`ifdef TT_SCAN_COMPARE_EN
    for (int k = 15; k >= 0; k--) begin
      if (diff[k]) begin
        exp_mis  = 1'b1;
        exp_fidx = 4'(k);
      end
    end
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    chk({name, "_done_drop"}, obs_done, 0);
    while (!obs_done && j < 200) begin
      chk({name, "_vec"}, {obs_busy, obs_abcd}, {1'b1, 4'(j / (s + 1))});
      @(negedge clk);
      j++;
    end
    chk({name, "_done_latency"}, j, 16 * (s + 1));
    chk({name, "_busy_end"}, obs_busy, 0);
    chk({name, "_table"}, obs_tab, exp_tab);
    chk({name, "_mismatch"}, obs_mis, exp_mis);
    chk({name, "_fail_idx"}, obs_fidx, exp_fidx);
    repeat (3) @(negedge clk);
    chk({name, "_done_hold"}, {obs_done, obs_tab}, {1'b1, exp_tab});
  endtask

  task automatic wait_vec(input logic [3:0] target, output int cycles);
    cycles = 0;
    while (obs_abcd !== target && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) chk("wait_vec_timeout", cycles, 0);
  endtask

  initial begin
    int c;
    rst        = 1'b1;
    start      = 1'b0;
    sel        = 1'b0;
    gate_mode  = 0;
    fault_mask = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_a", {abcd_a, busy_a, done_a, tab_a, mis_a, fidx_a}, 0);
    chk("reset_b", {abcd_b, busy_b, done_b, tab_b, mis_b, fidx_b}, 0);

    do_scan(1'b0, 0, 16'h0, "good");
    chk("good_const", tab_a, 16'h1BBB);
    do_scan(1'b0, 1, 16'h0, "stuck0");
    chk("stuck0_const", tab_a, 16'h0000);
    do_scan(1'b0, 2, 16'h0, "bit13");
    chk("bit13_const", tab_a, 16'h3BBB);

    // Mid-scan: extra start at vector 5 is ignored, rst at vector 7 aborts the scan.
    sel       = 1'b0;
    gate_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(4'd5, c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(4'd7, c);
    chk("ignored_start_timing", c + 1, 10);
    chk("ignored_start_busy", {busy_a, done_a}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan_reset", {abcd_a, busy_a, done_a, tab_a, mis_a, fidx_a}, 0);
    repeat (2) @(negedge clk);
    chk("midscan_idle", {abcd_a, busy_a, done_a}, 0);
    do_scan(1'b0, 0, 16'h0, "after_rst");

    do_scan(1'b1, 0, 16'h0, "fast_good");
    chk("fast_const", tab_b, 16'h1BBB);
    do_scan(1'b1, 1, 16'h0, "fast_stuck0");

    for (int r = 0; r < 4; r++) begin
      logic [15:0] fm;
      fm = 16'($urandom);
      if (r == 0) fm = 16'h0;
      do_scan(1'($urandom_range(0, 1)), 3, fm, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
